// File: rtl/adsr_envelope.sv
// adsr_envelope
//   Scales each incoming harmonic sample by an ADSR amplitude envelope.
//   The envelope advances once per sample strobe; the scaled sample
//   appears one cycle after its input strobe.
//
// Ports
//   clk, reset         : clock, asynchronous active-high reset
//   note_start         : pulse, note begins / retriggers (wins over note_done)
//   note_done          : pulse, note released
//   sample_in(_ready)  : signed sample and its one-cycle strobe ("tick")
//   attack/decay/release_step, sustain_level : envelope controls, read each tick
//   sample_out(_valid) : enveloped sample, valid one cycle after each tick
//   env_state          : IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   env_active         : state != IDLE
//   env_done           : one-cycle pulse when RELEASE reaches amplitude 0
module adsr_envelope #(
  parameter int SAMPLE_W = 16,
  parameter int AMP_W    = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       note_start,
  input  logic                       note_done,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_in_ready,
  input  logic [AMP_W-1:0]           attack_step,
  input  logic [AMP_W-1:0]           decay_step,
  input  logic [AMP_W-1:0]           sustain_level,
  input  logic [AMP_W-1:0]           release_step,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_out_valid,
  output logic [2:0]                 env_state,
  output logic                       env_active,
  output logic                       env_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } env_state_t;

  localparam logic [AMP_W-1:0] FS = {AMP_W{1'b1}};
  localparam int               PW = SAMPLE_W + AMP_W + 1;

  env_state_t           state, state_nxt, pulse_state;
  logic [AMP_W-1:0]     amp, amp_nxt;
  logic                 done_nxt;
  logic [AMP_W:0]       att_sum, dec_floor;
  logic signed [PW-1:0] prod;

  // State after this cycle's note pulses; the tick rule below uses it.
  always_comb begin
    pulse_state = state;
    if (note_start)
      pulse_state = S_ATTACK;
    else if (note_done && (state == S_ATTACK || state == S_DECAY || state == S_SUSTAIN))
      pulse_state = S_RELEASE;
  end

  // One extra bit so the sums cannot wrap.
  assign att_sum   = {1'b0, amp} + {1'b0, attack_step};
  assign dec_floor = {1'b0, sustain_level} + {1'b0, decay_step};

  always_comb begin
    state_nxt = pulse_state;
    amp_nxt   = amp;
    done_nxt  = 1'b0;
    if (sample_in_ready) begin
      case (pulse_state)
        S_ATTACK: begin
          if (attack_step == '0 || att_sum >= {1'b0, FS}) begin
            amp_nxt   = FS;
            // A full-scale sustain leaves nothing to decay through.
            state_nxt = (sustain_level == FS) ? S_SUSTAIN : S_DECAY;
          end else begin
            amp_nxt = att_sum[AMP_W-1:0];
          end
        end
        S_DECAY: begin
          // amp - step <= sustain  <=>  amp <= sustain + step; this also
          // snaps amp up if sustain_level was raised above it mid-decay.
          if (decay_step == '0 || {1'b0, amp} <= dec_floor) begin
            amp_nxt   = sustain_level;
            state_nxt = S_SUSTAIN;
          end else begin
            amp_nxt = amp - decay_step;
          end
        end
        S_SUSTAIN: amp_nxt = sustain_level;
        S_RELEASE: begin
          if (release_step == '0 || amp <= release_step) begin
            amp_nxt   = '0;
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            amp_nxt = amp - release_step;
          end
        end
        default: amp_nxt = '0;
      endcase
    end
  end

  // Signed product with a zero-extended amplitude; the arithmetic shift
  // floors toward -inf and the result always fits SAMPLE_W.
  assign prod = PW'(sample_in) * PW'($signed({1'b0, amp}));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      amp              <= '0;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      env_done         <= 1'b0;
    end else begin
      state            <= state_nxt;
      amp              <= amp_nxt;
      env_done         <= done_nxt;
      sample_out_valid <= sample_in_ready;
      if (sample_in_ready)
        sample_out <= SAMPLE_W'(prod >>> AMP_W);
    end
  end

  assign env_state  = state;
  assign env_active = (state != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
module tb_adsr_envelope;
  localparam int SW = 16;
  localparam int AW = 15;
  localparam int FS = 32767;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 note_start = 1'b0, note_done = 1'b0, sample_in_ready = 1'b0;
  logic signed [SW-1:0] sample_in = '0;
  logic [AW-1:0]        attack_step = '0, decay_step = '0, sustain_level = '0, release_step = '0;
  logic signed [SW-1:0] sample_out;
  logic                 sample_out_valid;
  logic [2:0]           env_state;
  logic                 env_active, env_done;

  int checks = 0;
  int errors = 0;

  adsr_envelope #(.SAMPLE_W(SW), .AMP_W(AW)) dut (
    .clk(clk), .reset(reset),
    .note_start(note_start), .note_done(note_done),
    .sample_in(sample_in), .sample_in_ready(sample_in_ready),
    .attack_step(attack_step), .decay_step(decay_step),
    .sustain_level(sustain_level), .release_step(release_step),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .env_state(env_state), .env_active(env_active), .env_done(env_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (phase + integer amplitude) ----------
  int m_st, m_amp, m_out;
  bit m_v, m_done;

  function automatic int floor_div(input longint n);
    longint q;
    q = n / 32768;
    if ((n % 32768) != 0 && n < 0) q = q - 1;
    return int'(q);
  endfunction

  function automatic void model_reset();
    m_st = 0; m_amp = 0; m_out = 0; m_v = 0; m_done = 0;
  endfunction

  function automatic void model_step(input bit ns, nd, rdy, input int s, as_, ds, sl, rs);
    int t;
    m_done = 0;
    if (ns) m_st = 1;
    else if (nd && m_st >= 1 && m_st <= 3) m_st = 4;
    m_v = rdy;
    if (rdy) begin
      m_out = floor_div(longint'(s) * longint'(m_amp));
      case (m_st)
        1: begin
          t = m_amp + as_;
          m_amp = (as_ == 0 || t > FS) ? FS : t;
          if (m_amp == FS) m_st = (sl == FS) ? 3 : 2;
        end
        2: begin
          t = m_amp - ds;
          m_amp = (ds == 0 || t < sl) ? sl : t;
          if (m_amp == sl) m_st = 3;
        end
        3: m_amp = sl;
        4: begin
          t = m_amp - rs;
          m_amp = (rs == 0 || t < 0) ? 0 : t;
          if (m_amp == 0) begin m_st = 0; m_done = 1; end
        end
        default: m_amp = 0;
      endcase
    end
  endfunction

  // ---------------- helpers ----------------------------------------------
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs, clock once, land 1ns after the edge.
  task automatic step(input bit ns, nd, rdy, input int s, as_, ds, sl, rs);
    note_start      = ns;
    note_done       = nd;
    sample_in_ready = rdy;
    sample_in       = SW'(s);
    attack_step     = AW'(as_);
    decay_step      = AW'(ds);
    sustain_level   = AW'(sl);
    release_step    = AW'(rs);
    @(posedge clk); #1;
    note_start = 1'b0; note_done = 1'b0; sample_in_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit ns, nd, rdy;
    int sin, as_, ds, sl, rs;
    bit ev; int eout; int est; bit edone;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit ns, nd, rdy, input int sin, as_, ds, sl, rs,
                              input bit ev, input int eout, est, input bit edone);
    vec_t v;
    v.ns = ns; v.nd = nd; v.rdy = rdy; v.sin = sin;
    v.as_ = as_; v.ds = ds; v.sl = sl; v.rs = rs;
    v.ev = ev; v.eout = eout; v.est = est; v.edone = edone;
    tbl.push_back(v);
  endfunction

  function automatic int pick_step();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return int'($urandom_range(16384, FS));
    return int'($urandom_range(1, 3000));
  endfunction

  initial begin
    // Reset state while reset is held
    #12;
    chk("rst_out",    $signed(sample_out), 0);
    chk("rst_valid",  sample_out_valid, 0);
    chk("rst_state",  env_state, 0);
    chk("rst_active", env_active, 0);
    chk("rst_done",   env_done, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    //   ns nd rdy  sin     as     ds    sl     rs     v  out    st done
    for (int i = 0; i < 5; i++)
      add(0, 0, 1, 1000,  16384, 8192, 16384, 10000, 1, 0,     0, 0);
    add(0, 0, 0, 1000,    16384, 8192, 16384, 10000, 0, 0,     0, 0);
    // attack / decay / sustain
    add(1, 0, 0, 20000,   16384, 8192, 16384, 10000, 0, 0,     1, 0);
    add(0, 0, 1, 20000,   16384, 8192, 16384, 10000, 1, 0,     1, 0);
    add(0, 0, 1, 20000,   16384, 8192, 16384, 10000, 1, 10000, 2, 0);
    add(0, 0, 1, 20000,   16384, 8192, 16384, 10000, 1, 19999, 2, 0);
    add(0, 0, 1, 20000,   16384, 8192, 16384, 10000, 1, 14999, 3, 0);
    add(0, 0, 1, 20000,   16384, 8192, 16384, 10000, 1, 10000, 3, 0);
    // release with negative sample
    add(0, 1, 1, -20000,  16384, 8192, 16384, 10000, 1, -10000, 4, 0);
    add(0, 0, 1, -20000,  16384, 8192, 16384, 10000, 1, -3897, 0, 1);
    add(0, 0, 0, -20000,  16384, 8192, 16384, 10000, 0, -3897, 0, 0);
    // note_done alone in IDLE is ignored
    add(0, 1, 0, 0,       16384, 8192, 16384, 10000, 0, -3897, 0, 0);
    // retrigger from RELEASE at amp 6000
    add(1, 0, 1, 0,       6000,  8192, 16384, 10000, 1, 0,     1, 0);
    add(0, 1, 0, 0,       6000,  8192, 16384, 10000, 0, 0,     4, 0);
    add(1, 0, 1, 32767,   1000,  8192, 16384, 10000, 1, 5999,  1, 0);
    add(0, 0, 1, 32767,   1000,  8192, 16384, 10000, 1, 6999,  1, 0);
    // zero steps jump straight to target; live sustain tracking
    add(0, 0, 1, 100,     0,     0,    16384, 10000, 1, 24,    2, 0);
    add(0, 0, 1, 100,     0,     0,    16384, 10000, 1, 99,    3, 0);
    add(0, 0, 1, 32767,   0,     0,    8192,  10000, 1, 16383, 3, 0);
    // start+done together in SUSTAIN -> ATTACK
    add(1, 1, 0, 0,       1000,  0,    8192,  10000, 0, 16383, 1, 0);
    add(0, 0, 1, -1,      1000,  0,    8192,  10000, 1, -1,    1, 0);
    add(0, 1, 1, 1000,    1000,  0,    8192,  0,     1, 280,   0, 1);
    // full-scale sustain skips DECAY
    add(1, 0, 1, 0,       0,     0,    32767, 0,     1, 0,     3, 0);
    add(0, 0, 1, 32767,   0,     0,    32767, 0,     1, 32766, 3, 0);

    foreach (tbl[i]) begin
      step(tbl[i].ns, tbl[i].nd, tbl[i].rdy, tbl[i].sin,
           tbl[i].as_, tbl[i].ds, tbl[i].sl, tbl[i].rs);
      chk($sformatf("row%0d_valid", i),  sample_out_valid, tbl[i].ev);
      chk($sformatf("row%0d_out", i),    $signed(sample_out), tbl[i].eout);
      chk($sformatf("row%0d_state", i),  env_state, tbl[i].est);
      chk($sformatf("row%0d_active", i), env_active, (tbl[i].est != 0));
      chk($sformatf("row%0d_done", i),   env_done, tbl[i].edone);
    end

    // Asynchronous reset in the middle of ATTACK
    do_reset();
    step(1, 0, 1, 1000, 1000, 0, 0, 0);
    chk("mid_state0", env_state, 1);
    step(0, 0, 1, 30000, 1000, 0, 0, 0);
    chk("mid_out", $signed(sample_out), 915);
    chk("mid_valid", sample_out_valid, 1);
    #3 reset = 1'b1;
    #1;
    chk("arst_out",    $signed(sample_out), 0);
    chk("arst_valid",  sample_out_valid, 0);
    chk("arst_state",  env_state, 0);
    chk("arst_active", env_active, 0);
    chk("arst_done",   env_done, 0);
    sample_in_ready = 1'b1;
    @(posedge clk); #1;
    chk("arst_hold_valid", sample_out_valid, 0);
    sample_in_ready = 1'b0;
    reset = 1'b0;
    step(0, 0, 1, 20000, 1000, 0, 0, 0);
    chk("post_rst_out",   $signed(sample_out), 0);
    chk("post_rst_valid", sample_out_valid, 1);
    chk("post_rst_state", env_state, 0);
    chk("post_rst_done",  env_done, 0);

    // Randomized run against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit ns, nd, rdy;
      int s, as_, ds, sl, rs;
      ns  = ($urandom_range(0, 39) == 0);
      nd  = ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      s   = int'($urandom_range(0, 65535)) - 32768;
      as_ = pick_step();
      ds  = pick_step();
      rs  = pick_step();
      sl  = ($urandom_range(0, 9) == 0) ? FS : int'($urandom_range(0, FS));
      step(ns, nd, rdy, s, as_, ds, sl, rs);
      model_step(ns, nd, rdy, s, as_, ds, sl, rs);
      chk("rnd_valid",  sample_out_valid, m_v);
      chk("rnd_out",    $signed(sample_out), m_out);
      chk("rnd_state",  env_state, m_st);
      chk("rnd_active", env_active, (m_st != 0));
      chk("rnd_done",   env_done, m_done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
